// File: rtl/mem_pkg.sv
// Shared definitions for the synchronous data memory:
// access-size encodings, FSM states and alignment check.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    return (size == SZ_HALF && off[0]) ||
           (size == SZ_WORD && off != 2'b00);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data/enables towards memory
// and load data extraction with sign/zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_st_word,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_off,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_ld_word,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_bsx;
  logic        w_hsx;

  always_comb begin
    o_be      = 4'b0000;
    o_st_word = i_st_data;
    case (i_st_size)
      SZ_BYTE: begin
        o_be      = 4'b0001 << i_st_off;
        o_st_word = {4{i_st_data[7:0]}};
      end
      SZ_HALF: begin
        o_be      = i_st_off[1] ? 4'b1100 : 4'b0011;
        o_st_word = {2{i_st_data[15:0]}};
      end
      SZ_WORD: o_be = 4'b1111;
      default: o_be = 4'b0000;
    endcase
  end

  assign w_byte = i_ld_word[{i_ld_off, 3'b000} +: 8];
  assign w_half = i_ld_off[1] ? i_ld_word[31:16]
                              : i_ld_word[15:0];
  assign w_bsx  = !i_ld_unsigned && w_byte[7];
  assign w_hsx  = !i_ld_unsigned && w_half[15];

  always_comb begin
    o_ld_data = i_ld_word;
    case (i_ld_size)
      SZ_BYTE: o_ld_data = {{24{w_bsx}}, w_byte};
      SZ_HALF: o_ld_data = {{16{w_hsx}}, w_half};
      default: o_ld_data = i_ld_word;
    endcase
  end

endmodule

// File: rtl/data_mem_sync.sv
// Clocked byte/half/word data memory with wait states,
// valid/ready request handshake and fault reporting.
module data_mem_sync
  import mem_pkg::*;
#(
  parameter int    DATA_W      = 32,
  parameter int    DEPTH       = 128,
  parameter int    ADDR_W      = 32,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LD =
    4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [ADDR_W-3:0] DEPTH_W =
    (ADDR_W-2)'(DEPTH);

  state_t r_state;
  state_t w_state_n;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_n;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rd_word;
  logic              r_err;

  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept;
  logic              w_commit;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_size;
  logic [DATA_W-1:0] w_wdata;
  logic [IW-1:0]     w_midx;
  logic              w_oob;
  logic              w_err;
  logic [3:0]        w_be;
  logic [31:0]       w_st_word;
  logic [31:0]       w_ld_data;

  initial begin
    for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;
  end

  assign req_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;

  // Zero-wait requests reach memory on the accept edge,
  // before the request registers hold them.
  assign w_we    = (r_state == ST_IDLE) ? req_we    : r_we;
  assign w_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
  assign w_size  = (r_state == ST_IDLE) ? req_size  : r_size;
  assign w_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;

  assign w_midx = w_addr[IW+1:2];
  assign w_oob  = w_addr[ADDR_W-1:2] >= DEPTH_W;
  assign w_err  = (w_size == SZ_ILL) || w_oob ||
                  is_misaligned(w_size, w_addr[1:0]);

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_state_n = ST_RESP;
          end else begin
            w_state_n = ST_WAIT;
            w_cnt_n   = WAIT_LD;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) w_state_n = ST_RESP;
        else               w_cnt_n   = r_cnt - 4'd1;
      end
      ST_RESP: w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end

  assign w_commit = !rst && (w_state_n == ST_RESP) &&
                    (r_state != ST_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_rsp_valid <= (r_state == ST_RESP);
      if (r_state == ST_RESP) begin
        r_rsp_err   <= r_err;
        r_rsp_rdata <= (r_err || r_we) ? '0 : w_ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_size  <= req_size;
      r_uns   <= req_unsigned;
      r_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_rd_word <= r_mem[w_midx];
      r_err     <= w_err;
      if (w_we && !w_err) begin
        for (int b = 0; b < 4; b++) begin
          if (w_be[b]) begin
            r_mem[w_midx][8*b +: 8] <= w_st_word[8*b +: 8];
          end
        end
      end
    end
  end

  mem_lane_align u_align (
    .i_st_size    (w_size),
    .i_st_off     (w_addr[1:0]),
    .i_st_data    (w_wdata),
    .o_be         (w_be),
    .o_st_word    (w_st_word),
    .i_ld_size    (r_size),
    .i_ld_off     (r_addr[1:0]),
    .i_ld_unsigned(r_uns),
    .i_ld_word    (r_rd_word),
    .o_ld_data    (w_ld_data)
  );

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_sync.sv
// Scoreboard bench: byte-array reference model, random and
// directed traffic, plus zero-wait and reset-abort instances.
module tb_data_mem_sync;

  localparam int DEPTH = 128;
  localparam int W1    = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // main instance, WAIT_CYCLES = 1
  logic        rst;
  logic        valid, ready, we, uns;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        rvalid, rerr;
  logic [31:0] rdata;

  data_mem_sync #(.DEPTH(DEPTH), .WAIT_CYCLES(W1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(valid), .req_ready(ready),
    .req_we(we), .req_addr(addr), .req_size(size),
    .req_unsigned(uns), .req_wdata(wdata),
    .rsp_valid(rvalid), .rsp_rdata(rdata), .rsp_err(rerr)
  );

  // zero-wait instance
  logic        v0, rdy0, rv0, re0;
  logic [31:0] rd0;

  data_mem_sync #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(v0), .req_ready(rdy0),
    .req_we(1'b0), .req_addr(32'h0), .req_size(2'b10),
    .req_unsigned(1'b0), .req_wdata(32'h0),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0)
  );

  // three-wait instance with its own reset
  logic        rst3, v3, rdy3, we3, rv3, re3;
  logic [31:0] wd3, rd3;

  data_mem_sync #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst3),
    .req_valid(v3), .req_ready(rdy3),
    .req_we(we3), .req_addr(32'h8), .req_size(2'b10),
    .req_unsigned(1'b0), .req_wdata(wd3),
    .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(re3)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];
  logic [7:0] mem_m [DEPTH*4];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_op(input logic we_i,
                          input logic [31:0] a,
                          input logic [1:0] sz,
                          input logic un,
                          input logic [31:0] wd,
                          output logic [31:0] rd,
                          output logic er);
    int n;
    logic [31:0] v;
    n  = 1 << sz;
    er = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
         (sz == 2'd2 && a[1:0] != 2'd0) ||
         ((a >> 2) >= DEPTH);
    rd = 32'h0;
    if (!er && we_i) begin
      for (int i = 0; i < n; i++)
        mem_m[int'(a) + i] = wd[8*i +: 8];
    end else if (!er) begin
      v = 32'h0;
      for (int i = 0; i < n; i++)
        v = v | (32'(mem_m[int'(a) + i]) << (8*i));
      if (n < 4 && !un && v[8*n-1])
        v = v | (32'hFFFF_FFFF << (8*n));
      rd = v;
    end
  endtask

  task automatic issue(input logic we_i,
                       input logic [31:0] a,
                       input logic [1:0] sz,
                       input logic un,
                       input logic [31:0] wd);
    exp_t e;
    int   t;
    @(negedge clk);
    we = we_i; addr = a; size = sz;
    uns = un; wdata = wd; valid = 1'b1;
    t = 0;
    while (!ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: ready %b want 1", ready);
      valid = 1'b0;
      return;
    end
    model_op(we_i, a, sz, un, wd, e.rdata, e.err);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    valid = 1'b0;
    we    = 1'($urandom);
    addr  = $urandom;
    size  = 2'($urandom);
    wdata = $urandom;
  endtask

  always @(negedge clk) begin
    if (!rst && rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rsp: rvalid %b want 0",
                 rvalid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdata", rdata, e.rdata);
        chk("err", 32'(rerr), 32'(e.err));
        chk("latency", 32'(cyc - e.acc), 32'(1 + W1));
      end
    end
  end

  task automatic wait_rsp3(output int seen);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (rv3) seen = 1;
    end
  endtask

  initial begin
    int   t, seen;
    logic [1:0]  sz;
    logic [31:0] a;

    for (int i = 0; i < DEPTH*4; i++) mem_m[i] = 8'h00;
    rst = 1'b1; rst3 = 1'b1;
    valid = 1'b0; we = 1'b0; addr = '0; size = '0;
    uns = 1'b0; wdata = '0;
    v0 = 1'b0; v3 = 1'b0; we3 = 1'b0; wd3 = '0;

    repeat (3) @(negedge clk);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(rerr), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    rst = 1'b0; rst3 = 1'b0;
    #1;
    chk("ready_after_rst", 32'(ready), 32'd1);

    // byte lanes into a fresh word
    issue(1, 32'h13, 2'd0, 0, 32'h0000_00AB);
    issue(0, 32'h10, 2'd2, 0, 32'h0);
    issue(0, 32'h13, 2'd0, 0, 32'h0);
    issue(0, 32'h13, 2'd0, 1, 32'h0);
    // word round trip with top bit set
    issue(1, 32'h10, 2'd2, 0, 32'h8000_00FF);
    issue(0, 32'h10, 2'd2, 0, 32'h0);
    // halves and faulting accesses
    issue(1, 32'h22, 2'd1, 0, 32'h0000_1234);
    issue(0, 32'h22, 2'd1, 0, 32'h0);
    issue(0, 32'h21, 2'd1, 0, 32'h0);
    issue(1, 32'h21, 2'd2, 0, 32'hDEAD_BEEF);
    issue(0, 32'h20, 2'd2, 0, 32'h0);
    issue(0, 32'h200, 2'd2, 0, 32'h0);
    issue(0, 32'h10, 2'd3, 0, 32'h0);
    issue(1, 32'h1FC, 2'd2, 0, 32'hCAFE_F00D);
    issue(0, 32'h1FC, 2'd2, 0, 32'h0);
    issue(0, 32'h1FE, 2'd1, 0, 32'h0);

    for (int k = 0; k < 300; k++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 'h21F));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3)
        a = a & ~((32'd1 << sz) - 32'd1);
      issue(1'($urandom), a, sz, 1'($urandom), $urandom);
    end

    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(sb.size()), 32'd0);

    // zero wait: held valid gives one accept every 2 cycles
    @(negedge clk);
    v0 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk("w0_ready", 32'(rdy0), 32'(k % 2 == 0));
      chk("w0_rvalid", 32'(rv0),
          32'(k >= 2 && k % 2 == 0));
      if (rv0) chk("w0_rdata", rd0, 32'd0);
      @(negedge clk);
    end
    v0 = 1'b0;

    // three waits: commit a value, then abort a second store
    we3 = 1'b1; wd3 = 32'h1111_1111; v3 = 1'b1;
    t = 0;
    while (!rdy3 && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1 v3 = 1'b0;
    wait_rsp3(seen);
    chk("w3_first_rsp", 32'(seen), 32'd1);
    chk("w3_first_err", 32'(re3), 32'd0);

    @(negedge clk);
    wd3 = 32'h2222_2222; v3 = 1'b1;
    chk("w3_ready_idle", 32'(rdy3), 32'd1);
    @(posedge clk);
    @(negedge clk);
    v3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    chk("w3_ready_in_rst", 32'(rdy3), 32'd0);
    rst3 = 1'b0;
    @(negedge clk);
    chk("w3_ready_post", 32'(rdy3), 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (rv3) seen++;
      @(negedge clk);
    end
    chk("w3_no_rsp", 32'(seen), 32'd0);

    we3 = 1'b0; v3 = 1'b1;
    @(posedge clk);
    #1 v3 = 1'b0;
    wait_rsp3(seen);
    chk("w3_load_rsp", 32'(seen), 32'd1);
    chk("w3_load_data", rd3, 32'h1111_1111);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_err);
    $finish;
  end

endmodule
